cordic_trig_scheduler: RTL and testbench

CORDIC_TRIG_SCHEDULER -- requirements
Module: cordic_trig_scheduler

---
 rtl/cordic_sched_pkg.sv | 20 ++
 rtl/cordic_trig_scheduler_if.sv | 42 ++++
 rtl/cordic_rr_pick.sv | 38 +++
 rtl/cordic_trig_scheduler.sv | 153 +++++++++++++++
 tb/tb_cordic_trig_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_sched_pkg.sv
// Shared definitions for the CORDIC trig request scheduler.
// Contents: FSM state enum, default parameter values, watchdog counter width.
package cordic_sched_pkg;

    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned ANGLE_W_DEF = 16;
    localparam int unsigned RES_W_DEF   = 32;
    localparam int unsigned TIMEOUT_DEF = 64;

    // Watchdog counter width; covers the largest allowed TIMEOUT (255).
    localparam int unsigned WD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/cordic_trig_scheduler_if.sv
// Bus bundle between requesters, the scheduler, the CORDIC engine and the
// response consumer.
// slave  : scheduler side (drives req_ready, eng_start/eng_angle, rsp_*).
// master : environment side (requesters, engine, consumer).
interface cordic_trig_scheduler_if
    import cordic_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned ANGLE_W = ANGLE_W_DEF,
    parameter int unsigned RES_W   = RES_W_DEF
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*ANGLE_W-1:0] req_angle;
    logic [N_REQ-1:0]         req_ready;

    logic                     eng_start;
    logic [ANGLE_W-1:0]       eng_angle;
    logic                     eng_ready;
    logic                     eng_done;
    logic [RES_W-1:0]         eng_cosine;
    logic [RES_W-1:0]         eng_sine;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [RES_W-1:0]         rsp_cosine;
    logic [RES_W-1:0]         rsp_sine;
    logic                     rsp_err;

    modport slave (
        input  req_valid, req_angle, eng_ready, eng_done, eng_cosine, eng_sine, rsp_ready,
        output req_ready, eng_start, eng_angle, rsp_valid, rsp_id, rsp_cosine, rsp_sine, rsp_err
    );

    modport master (
        output req_valid, req_angle, eng_ready, eng_done, eng_cosine, eng_sine, rsp_ready,
        input  req_ready, eng_start, eng_angle, rsp_valid, rsp_id, rsp_cosine, rsp_sine, rsp_err
    );

endinterface

// File: rtl/cordic_rr_pick.sv
// Combinational round-robin picker.
// req         : pending request vector
// ptr         : index where the search starts
// grant_valid : some request is pending
// grant_idx   : first pending index at or after ptr, wrapping modulo N_REQ
module cordic_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_idx
);

    int unsigned    pos;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        pos         = 0;
        idx         = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            // ptr < N_REQ, so one conditional subtract implements the wrap.
            pos = 32'(ptr) + off;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            idx = ID_W'(pos);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/cordic_trig_scheduler.sv
// Shares one CORDIC trig engine among N_REQ requesters, one transaction at a
// time, with round-robin arbitration and a watchdog on the engine.
// clk  : single clock, rising edge
// rst  : synchronous active-high reset, highest priority
// bus  : requester / engine / response signals (slave side)
// busy : high whenever the FSM is not IDLE
module cordic_trig_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned ANGLE_W = ANGLE_W_DEF,
    parameter int unsigned RES_W   = RES_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    cordic_trig_scheduler_if.slave  bus,
    output logic                    busy
);

    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_RESP  = RESP;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;
    logic [WD_W-1:0]    wd;
    logic               grant;
    logic               capture;
    logic               expire;
    logic [ANGLE_W-1:0] grant_angle;

    cordic_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req         (bus.req_valid),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Angle slice of the requester currently selected by the picker.
    always_comb begin
        grant_angle = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_angle = bus.req_angle[i*ANGLE_W +: ANGLE_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and combinational accept strobe; req_ready is masked by rst
    // so a requester never sees an accept that reset would discard.
    always_comb begin
        state_next    = state;
        grant         = 1'b0;
        capture       = 1'b0;
        expire        = 1'b0;
        bus.req_ready = '0;
        case (state)
            ST_IDLE: begin
                if (!rst && grant_valid && bus.eng_ready) begin
                    grant                    = 1'b1;
                    bus.req_ready[grant_idx] = 1'b1;
                    state_next               = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                // eng_done wins over a coincident watchdog expiry.
                if (bus.eng_done) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    expire     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: grant bookkeeping, watchdog, response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr            <= '0;
            cur_id         <= '0;
            wd             <= '0;
            busy           <= 1'b0;
            bus.eng_start  <= 1'b0;
            bus.eng_angle  <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_cosine <= '0;
            bus.rsp_sine   <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            busy          <= (state_next != ST_IDLE);
            bus.eng_start <= grant;

            if (grant) begin
                ptr           <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                cur_id        <= grant_idx;
                bus.eng_angle <= grant_angle;
            end

            if (state == ST_ISSUE) begin
                wd <= '0;
            end else if (state == ST_WAIT) begin
                wd <= wd + WD_W'(1);
            end

            if (capture) begin
                bus.rsp_valid  <= 1'b1;
                bus.rsp_id     <= cur_id;
                bus.rsp_cosine <= bus.eng_cosine;
                bus.rsp_sine   <= bus.eng_sine;
                bus.rsp_err    <= 1'b0;
            end else if (expire) begin
                bus.rsp_valid  <= 1'b1;
                bus.rsp_id     <= cur_id;
                bus.rsp_cosine <= '0;
                bus.rsp_sine   <= '0;
                bus.rsp_err    <= 1'b1;
            end else if (state == ST_RESP && bus.rsp_ready) begin
                bus.rsp_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_trig_scheduler.sv
// Self-checking bench for cordic_trig_scheduler: transaction-level reference
// model checked every cycle, directed scenarios, then randomized traffic.
module tb_cordic_trig_scheduler;
    import cordic_sched_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned RW = 32;
    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    cordic_trig_scheduler_if #(.N_REQ(N), .ANGLE_W(AW), .RES_W(RW)) bus ();

    cordic_trig_scheduler #(
        .N_REQ(N), .ANGLE_W(AW), .RES_W(RW), .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // engine model
    bit          eng_run = 0;
    int          done_at = -1;
    int          eng_lat = 18;
    int          lat;
    bit          lat_rand = 0;
    bit          use_dir = 1;
    logic [31:0] dir_cos = '0, dir_sin = '0, cur_cos = '0, cur_sin = '0;
    bit          stray_en = 0, rdy_jitter = 0;

    // requester / consumer / reset randomization
    bit rearm = 0, rand_req = 0, rand_rst = 0;

    // observations from the last checked cycle
    logic [N-1:0] obs_rr;
    bit           obs_rsp = 0, obs_start = 0, obs_busy = 0, obs_err = 0;
    logic [1:0]   obs_id;
    logic [31:0]  obs_cos, obs_sin;
    logic [15:0]  obs_angle;
    int           last_start = 0, last_rsp_rise = 0, start_count = 0, rsp_rises = 0;
    int           grant_log[$];

    // reference model
    bit          m_busy = 0, m_wait = 0, m_resp = 0;
    int          m_ptr = 0, t_start = 0;
    logic [15:0] m_angle = '0;
    int          e_id = 0;
    logic [31:0] e_cos = '0, e_sin = '0;
    bit          e_err = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Compare DUT outputs with the model for the current cycle, then advance
    // the model with this cycle's inputs.
    task automatic check();
        int          g = -1;
        bit          gr;
        logic [N-1:0] exp_rr;
        for (int i = 0; i < N; i++) begin
            int k = (m_ptr + i) % N;
            if (g < 0 && bus.req_valid[k]) g = k;
        end
        gr     = !m_busy && !rst && bus.eng_ready && (g >= 0);
        exp_rr = gr ? (N'(1) << g) : '0;

        chk("req_ready", bus.req_ready, exp_rr);
        chk("eng_start", bus.eng_start, m_busy && (cyc == t_start));
        chk("eng_angle", bus.eng_angle, m_angle);
        chk("busy", busy, m_busy);
        chk("rsp_valid", bus.rsp_valid, m_resp);
        if (m_resp) begin
            chk("rsp_id", bus.rsp_id, e_id);
            chk("rsp_cosine", bus.rsp_cosine, e_cos);
            chk("rsp_sine", bus.rsp_sine, e_sin);
            chk("rsp_err", bus.rsp_err, e_err);
        end

        for (int i = 0; i < N; i++) if (bus.req_ready[i]) grant_log.push_back(i);
        if (bus.rsp_valid && !obs_rsp) begin
            last_rsp_rise = cyc;
            rsp_rises++;
        end
        if (bus.eng_start) begin
            last_start = cyc;
            start_count++;
            eng_run = 1;
            if (lat_rand) lat = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 66));
            else          lat = eng_lat;
            done_at = (lat == 0) ? -1 : cyc + lat;
            cur_cos = use_dir ? dir_cos : $urandom;
            cur_sin = use_dir ? dir_sin : $urandom;
        end
        if (bus.rsp_valid && bus.rsp_err) eng_run = 0;
        if (rst && done_at < 0) eng_run = 0;

        obs_rr    = bus.req_ready;
        obs_rsp   = bus.rsp_valid;
        obs_start = bus.eng_start;
        obs_busy  = busy;
        obs_err   = bus.rsp_err;
        obs_id    = bus.rsp_id;
        obs_cos   = bus.rsp_cosine;
        obs_sin   = bus.rsp_sine;
        obs_angle = bus.eng_angle;

        if (rst) begin
            m_busy = 0; m_wait = 0; m_resp = 0; m_ptr = 0; m_angle = '0;
        end else if (gr) begin
            m_busy  = 1;
            m_wait  = 1;
            t_start = cyc + 1;
            e_id    = g;
            m_angle = bus.req_angle[g*AW +: AW];
            m_ptr   = (g + 1) % N;
        end else if (m_wait && cyc > t_start) begin
            if (bus.eng_done) begin
                e_cos = bus.eng_cosine; e_sin = bus.eng_sine; e_err = 0;
                m_wait = 0; m_resp = 1;
            end else if (cyc - t_start == TO) begin
                e_cos = '0; e_sin = '0; e_err = 1;
                m_wait = 0; m_resp = 1;
            end
        end else if (m_resp && bus.rsp_ready) begin
            m_resp = 0;
            m_busy = 0;
        end
    endtask

    // Environment inputs for the new cycle, applied just after the edge.
    task automatic drive();
        for (int i = 0; i < N; i++) if (obs_rr[i] && !rearm) bus.req_valid[i] = 1'b0;
        bus.eng_done = 1'b0;
        if (eng_run && done_at == cyc) begin
            bus.eng_done   = 1'b1;
            bus.eng_cosine = cur_cos;
            bus.eng_sine   = cur_sin;
            eng_run        = 0;
        end else if (stray_en && !eng_run && $urandom_range(0, 15) == 0) begin
            bus.eng_done   = 1'b1;
            bus.eng_cosine = $urandom;
            bus.eng_sine   = $urandom;
        end
        bus.eng_ready = !eng_run && !(rdy_jitter && $urandom_range(0, 3) == 0);
        if (rand_req) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                    bus.req_valid[i]          = 1'b1;
                    bus.req_angle[i*AW +: AW] = 16'($urandom);
                end else if (bus.req_valid[i] && $urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
        end
        if (rand_rst) rst = ($urandom_range(0, 299) == 0);
    endtask

    task automatic step();
        @(negedge clk);
        check();
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic wait_rsp(int max, string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!obs_rsp && n < max);
        if (!obs_rsp) chk({name, "_rsp_timeout"}, 0, 1);
    endtask

    task automatic drain(int max);
        int n = 0;
        do begin
            step();
            n++;
        end while ((obs_busy || obs_rsp) && n < max);
        if (obs_busy || obs_rsp) chk("drain_timeout", 0, 1);
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_eng_start"}, bus.eng_start, 0);
        chk({tag, "_eng_angle"}, bus.eng_angle, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_id"}, bus.rsp_id, 0);
        chk({tag, "_rsp_cosine"}, bus.rsp_cosine, 0);
        chk({tag, "_rsp_sine"}, bus.rsp_sine, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    int base, s0, r0, n;
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [31:0] snap_cos, snap_sin;
    logic [1:0]  snap_id;

    initial begin
        rst = 1'b1;
        bus.req_valid = '0; bus.req_angle = '0; bus.rsp_ready = 1'b1;
        bus.eng_ready = 1'b1; bus.eng_done = 1'b0; bus.eng_cosine = '0; bus.eng_sine = '0;
        obs_rr = '0;
        @(posedge clk);
        #1;
        step(); step();
        check_reset_vals("por");
        rst = 1'b0;

        // single request from requester 2
        use_dir = 1; dir_cos = 32'h0000_0000; dir_sin = 32'h0001_0000; eng_lat = 18;
        bus.req_angle[2*AW +: AW] = 16'h4000;
        bus.req_valid = 4'b0100;
        s0 = start_count;
        wait_rsp(100, "single");
        chk("single_id", obs_id, 2);
        chk("single_cos", obs_cos, 32'h0000_0000);
        chk("single_sin", obs_sin, 32'h0001_0000);
        chk("single_err", obs_err, 0);
        chk("single_angle", obs_angle, 16'h4000);
        chk("single_latency", last_rsp_rise - last_start, 19);
        drain(10);
        chk("single_starts", start_count - s0, 1);

        // fairness from ptr = 0
        rst = 1'b1; step(); rst = 1'b0;
        use_dir = 0; lat_rand = 0; eng_lat = 5; rearm = 1;
        for (int i = 0; i < N; i++) bus.req_angle[i*AW +: AW] = 16'($urandom);
        bus.req_valid = 4'b1111;
        base = grant_log.size();
        n = 0;
        while (grant_log.size() - base < 8 && n < 2000) begin
            step();
            n++;
        end
        rearm = 0; bus.req_valid = '0;
        for (int i = 0; i < 8; i++)
            chk("fair_order", (base + i < grant_log.size()) ? grant_log[base + i] : -1, exp_order[i]);
        drain(200);

        // backpressure
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        wait_rsp(200, "bp");
        bus.req_valid = 4'b1101;
        snap_id = obs_id; snap_cos = obs_cos; snap_sin = obs_sin;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", obs_rsp, 1);
            chk("bp_id", obs_id, snap_id);
            chk("bp_cos", obs_cos, snap_cos);
            chk("bp_sin", obs_sin, snap_sin);
            chk("bp_start", obs_start, 0);
            chk("bp_req_ready", obs_rr, 0);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.req_valid = '0;
        drain(200);

        // watchdog timeout
        eng_lat = 0;
        bus.req_valid = 4'b0001;
        wait_rsp(200, "timeout");
        chk("timeout_err", obs_err, 1);
        chk("timeout_cos", obs_cos, 0);
        chk("timeout_sin", obs_sin, 0);
        chk("timeout_latency", last_rsp_rise - last_start, 65);
        drain(20);

        // eng_done in the last watchdog cycle
        use_dir = 1; dir_cos = 32'h0000_B505; dir_sin = 32'hFFFF_4AFB; eng_lat = 64;
        bus.req_valid = 4'b1000;
        wait_rsp(200, "collide");
        chk("collide_err", obs_err, 0);
        chk("collide_cos", obs_cos, 32'h0000_B505);
        chk("collide_sin", obs_sin, 32'hFFFF_4AFB);
        chk("collide_latency", last_rsp_rise - last_start, 65);
        drain(20);

        // reset while waiting on the engine, late eng_done afterwards
        eng_lat = 30;
        bus.req_valid = 4'b0100;
        n = 0;
        while (!obs_start && n < 50) begin
            step();
            n++;
        end
        chk("mid_started", obs_start, 1);
        repeat (5) step();
        rst = 1'b1;
        step();
        check_reset_vals("mid");
        rst = 1'b0;
        r0 = rsp_rises;
        repeat (40) step();
        chk("mid_no_rsp", rsp_rises - r0, 0);
        bus.req_valid = 4'b1111;
        base = grant_log.size();
        n = 0;
        while (grant_log.size() == base && n < 100) begin
            step();
            n++;
        end
        chk("mid_first_grant", (grant_log.size() > base) ? grant_log[base] : -1, 0);
        bus.req_valid = '0;
        drain(200);

        // randomized traffic
        use_dir = 0; lat_rand = 1; stray_en = 1; rdy_jitter = 1; rand_req = 1; rand_rst = 1;
        repeat (4000) step();
        rand_req = 0; rand_rst = 0; stray_en = 0; rst = 1'b0;
        bus.req_valid = '0; bus.rsp_ready = 1'b1;
        drain(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
